// File: rtl/bus_arb_pkg.sv
// Shared constants and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  localparam int NUM_MST  = 3;

  // Requester slot assignments on the shared bus
  localparam int MST_CORE = 0;
  localparam int MST_SPI  = 1;
  localparam int MST_DMA  = 2;

  // Index following k in a ring of n requesters
  function automatic int rr_next(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set bit of i_pending at or above
// i_ptr, wrapping past the top index back to 0. Purely combinational.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_pending,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_winner
);

  int            sum;
  logic [PW-1:0] idx;
  logic          found;

  // Walk the ring starting at the pointer and keep only the first hit
  always_comb begin
    o_winner = '0;
    found    = 1'b0;
    sum      = 0;
    idx      = '0;
    for (int o = 0; o < N; o++) begin
      sum = int'(i_ptr) + o;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (!found && i_pending[idx]) begin
        o_winner[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one requester per cycle onto a shared
// single-cycle slave bus. Grants are registered; the bus fields of the
// granted requester are muxed combinationally during its grant cycle.
module bus_arbiter #(
  parameter int NUM_MST = bus_arb_pkg::NUM_MST,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_MST-1:0]    i_req,
  output logic [NUM_MST-1:0]    o_gnt,
  input  logic [NUM_MST*AW-1:0] i_addr,
  input  logic [NUM_MST*DW-1:0] i_wr_data,
  input  logic [NUM_MST*4-1:0]  i_size,
  input  logic [NUM_MST-1:0]    i_read,
  input  logic [NUM_MST-1:0]    i_write,
  output logic [DW-1:0]         o_rd_data,
  output logic [AW-1:0]         o_bus_addr,
  output logic [DW-1:0]         o_bus_wr_data,
  output logic [3:0]            o_bus_size,
  output logic                  o_bus_read,
  output logic                  o_bus_write,
  input  logic [DW-1:0]         i_bus_rd_data
);
  import bus_arb_pkg::*;

  localparam int PW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  logic [NUM_MST-1:0] pending_q, pending_d;
  logic [NUM_MST-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  // Low for the first edge after reset release so no grant issues on it
  logic               arm_q, arm_d;
  logic [NUM_MST-1:0] winner;

  // Latch new requests; a requester's own request is ignored while granted
  always_comb begin
    pending_d = (pending_q | i_req) & ~gnt_q;
  end

  // Arbitrate over the requests that will be pending after this edge, so an
  // uncontended pulse is granted on the very next cycle
  rr_pick #(
    .N  (NUM_MST),
    .PW (PW)
  ) u_rr_pick (
    .i_pending (pending_d),
    .i_ptr     (ptr_q),
    .o_winner  (winner)
  );

  // Next grant and pointer; pointer moves just past the winner
  always_comb begin
    gnt_d = arm_q ? winner : '0;
    ptr_d = ptr_q;
    arm_d = 1'b1;
    for (int k = 0; k < NUM_MST; k++) begin
      if (gnt_d[k]) ptr_d = PW'(rr_next(k, NUM_MST));
    end
  end

  // Arbitration state; reset drops any in-flight grant and pending request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= '0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      arm_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      arm_q     <= arm_d;
    end
  end

  // Mirror the granted requester onto the slave side; idle bus reads all zero
  always_comb begin
    o_bus_addr    = '0;
    o_bus_wr_data = '0;
    o_bus_size    = '0;
    o_bus_read    = 1'b0;
    o_bus_write   = 1'b0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (gnt_q[k]) begin
        o_bus_addr    = i_addr[k*AW +: AW];
        o_bus_wr_data = i_wr_data[k*DW +: DW];
        o_bus_size    = i_size[k*4 +: 4];
        o_bus_read    = i_read[k];
        o_bus_write   = i_write[k];
      end
    end
  end

  assign o_gnt     = gnt_q;
  assign o_rd_data = i_bus_rd_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a behavioural arbiter model.
module tb_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            i_clk;
  logic            i_rst_n;
  logic [N-1:0]    req, rd, wr, gnt;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*4-1:0]  size;
  logic [DW-1:0]   bus_rd, rdata, bwdata;
  logic [AW-1:0]   baddr;
  logic [3:0]      bsize;
  logic            bread, bwrite;

  int n_cmp;
  int n_mis;

  // Behavioural model state
  bit m_pend [N];
  int m_gnt;
  int m_ptr;
  bit m_arm;

  bus_arbiter #(.NUM_MST(N), .AW(AW), .DW(DW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (req),
    .o_gnt         (gnt),
    .i_addr        (addr),
    .i_wr_data     (wdata),
    .i_size        (size),
    .i_read        (rd),
    .i_write       (wr),
    .o_rd_data     (rdata),
    .o_bus_addr    (baddr),
    .o_bus_wr_data (bwdata),
    .o_bus_size    (bsize),
    .o_bus_read    (bread),
    .o_bus_write   (bwrite),
    .i_bus_rd_data (bus_rd)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_gnt = -1;
    m_ptr = 0;
    m_arm = 1'b0;
  endfunction

  // One clock edge of the arbiter as described by its rules
  task automatic model_step();
    bit eff [N];
    int g;
    int idx;
    if (!i_rst_n) return;
    g = -1;
    for (int i = 0; i < N; i++) eff[i] = (m_pend[i] || req[i]) && (m_gnt != i);
    if (m_arm) begin
      for (int o = 0; o < N; o++) begin
        idx = (m_ptr + o) % N;
        if (g < 0 && eff[idx]) g = idx;
      end
    end
    for (int i = 0; i < N; i++) m_pend[i] = eff[i];
    m_gnt = g;
    if (g >= 0) m_ptr = (g + 1) % N;
    m_arm = 1'b1;
  endtask

  task automatic check_outputs();
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [3:0]    es;
    logic          er, ew;
    eg = '0; ea = '0; ed = '0; es = '0; er = 1'b0; ew = 1'b0;
    if (m_gnt >= 0) begin
      eg[m_gnt] = 1'b1;
      ea = addr[m_gnt*AW +: AW];
      ed = wdata[m_gnt*DW +: DW];
      es = size[m_gnt*4 +: 4];
      er = rd[m_gnt];
      ew = wr[m_gnt];
    end
    chk("gnt", gnt, eg);
    chk("bus_addr", baddr, ea);
    chk("bus_wr_data", bwdata, ed);
    chk("bus_size", bsize, es);
    chk("bus_read", bread, er);
    chk("bus_write", bwrite, ew);
    chk("rd_data", rdata, bus_rd);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge
  task automatic step();
    #1;
    check_outputs();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic clear_inputs();
    req = '0; rd = '0; wr = '0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    m_reset();
    clear_inputs();
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  logic [N-1:0] prev;

  initial begin
    n_cmp = 0; n_mis = 0;
    i_clk = 1'b0; i_rst_n = 1'b0;
    req = '0; rd = '0; wr = '0; addr = '0; wdata = '0; size = '0; bus_rd = '0;
    m_reset();

    // Reset state
    @(negedge i_clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_bus_write", bwrite, 0);
    step();
    i_rst_n = 1'b1;
    step(); step(); step();

    // Scenario 1: single write by master 1
    req[1] = 1'b1;
    addr[1*AW +: AW]  = 32'h1000_0010;
    wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    size[1*4 +: 4]    = 4'b1111;
    step();
    req = '0;
    wr[1] = 1'b1;
    #1;
    chk("s1_gnt", gnt, 3'b010);
    chk("s1_write", bwrite, 1);
    chk("s1_addr", baddr, 32'h1000_0010);
    chk("s1_data", bwdata, 32'hDEAD_BEEF);
    chk("s1_size", bsize, 4'hF);
    step();
    wr = '0;
    chk("s1_one_cycle", gnt, 0);
    step();

    // Scenario 2: three simultaneous pulses from ptr=0
    do_reset();
    step();
    req = 3'b111;
    step();
    req = '0;
    chk("s2_g0", gnt, 3'b001);
    step();
    chk("s2_g1", gnt, 3'b010);
    step();
    chk("s2_g2", gnt, 3'b100);
    step();
    chk("s2_idle", gnt, 0);
    req = 3'b111;
    step();
    req = '0;
    chk("s2_ptr0", gnt, 3'b001);
    step(); step(); step();

    // Scenario 3: master 0 held high, master 2 pulsed
    do_reset();
    step();
    prev = '0;
    for (int c = 0; c < 10; c++) begin
      req = {(c % 2 == 1), 1'b0, 1'b1};
      step();
      chk("s3_busy", gnt != 0, 1);
      chk("s3_alt", gnt != prev, 1);
      prev = gnt;
    end
    req = '0;
    step(); step();

    // Scenario 4: read by master 0
    req[0] = 1'b1;
    step();
    req = '0;
    rd[0] = 1'b1;
    addr[0*AW +: AW] = 32'h0000_0040;
    bus_rd = 32'h1234_5678;
    #1;
    chk("s4_gnt", gnt, 3'b001);
    chk("s4_read", bread, 1);
    chk("s4_addr", baddr, 32'h0000_0040);
    chk("s4_rdata", rdata, 32'h1234_5678);
    step();
    rd = '0;
    step();

    // Scenario 5: reset during master 0's grant
    do_reset();
    step();
    req = 3'b011;
    step();
    req = '0;
    chk("s5_g0", gnt, 3'b001);
    i_rst_n = 1'b0;
    m_reset();
    #1;
    chk("s5_rst_gnt", gnt, 0);
    chk("s5_rst_addr", baddr, 0);
    step(); step();
    i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("s5_lost", gnt, 0);
    end

    // Scenario 7: request present at release is granted on the second edge
    i_rst_n = 1'b0;
    m_reset();
    step();
    req = 3'b100;
    i_rst_n = 1'b1;
    step();
    req = '0;
    chk("s7_first_edge", gnt, 0);
    step();
    chk("s7_second_edge", gnt, 3'b100);
    step();

    // Scenario 6: idle for 20 cycles with busy-looking side inputs
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW]  = $urandom;
        wdata[i*DW +: DW] = $urandom;
        size[i*4 +: 4]    = 4'($urandom);
      end
      rd = N'($urandom); wr = N'($urandom);
      step();
      chk("s6_idle", gnt, 0);
    end
    rd = '0; wr = '0;
    req = 3'b111;
    step();
    req = '0;
    step(); step(); step();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        i_rst_n = 1'b0;
        m_reset();
        step();
        i_rst_n = 1'b1;
      end
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      rd  = N'($urandom);
      wr  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW]  = $urandom;
        wdata[i*DW +: DW] = $urandom;
        size[i*4 +: 4]    = 4'($urandom);
      end
      bus_rd = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
